// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run sequencer for Simple_Single_CPU.
//   1. Streams a program into instruction memory (valid/ready handshake).
//   2. Releases the CPU for a programmed number of clock-enabled cycles.
//   3. Freezes the CPU and streams out every register-file entry.
//   4. Reports completion.
//
// Ports
//   clk_i, rst_i                     clock; async active-low reset
//   start_i, abort_i                 start (IDLE/DONE only); sync abort to IDLE
//   load_len_i, run_cycles_i         job parameters, latched on start
//   instr_valid_i/ready_o/data_i     program stream in
//   imem_we_o/addr_o/wdata_o         IMEM write port
//   cpu_rst_n_o, cpu_en_o            CPU reset (active-low) and clock enable
//   rf_raddr_o, rf_rdata_i           combinational-read register-file port
//   dump_valid_o/ready_i/idx_o/data_o  register dump stream out
//   busy_o, done_o, state_o          status (IDLE=0 LOAD=1 RUN=2 DUMP=3 DONE=4)
`timescale 1ns/1ps
module cpu_run_ctrl #(
  parameter int IMEM_AW   = 8,
  parameter int RUN_CNT_W = 16,
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [IMEM_AW:0]     load_len_i,
  input  logic [RUN_CNT_W-1:0] run_cycles_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [DATA_W-1:0]    instr_data_i,
  output logic                 imem_we_o,
  output logic [IMEM_AW-1:0]   imem_addr_o,
  output logic [DATA_W-1:0]    imem_wdata_o,
  output logic                 cpu_rst_n_o,
  output logic                 cpu_en_o,
  output logic [4:0]           rf_raddr_o,
  input  logic [DATA_W-1:0]    rf_rdata_i,
  output logic                 dump_valid_o,
  input  logic                 dump_ready_i,
  output logic [4:0]           dump_idx_o,
  output logic [DATA_W-1:0]    dump_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           state_o
);
  localparam int IDX_W = 5;
  localparam logic [IMEM_AW:0]     MAX_LEN  = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0]     LEN_ONE  = {{IMEM_AW{1'b0}}, 1'b1};
  localparam logic [RUN_CNT_W-1:0] RUN_ONE  = {{(RUN_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]     IDX_ONE  = 5'd1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_DUMP = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IMEM_AW:0]      r_len, w_len_nxt;
  logic [RUN_CNT_W-1:0]  r_run, w_run_nxt;
  logic [IMEM_AW:0]      r_ptr, w_ptr_nxt;
  logic [RUN_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic                  r_imem_we, w_imem_we_nxt;
  logic [IMEM_AW-1:0]    r_imem_addr, w_imem_addr_nxt;
  logic [DATA_W-1:0]     r_imem_wdata, w_imem_wdata_nxt;
  logic                  r_cpu_rst_n, w_cpu_rst_n_nxt;
  logic                  r_cpu_en, w_cpu_en_nxt;
  logic                  r_dvalid, w_dvalid_nxt;
  logic [IDX_W-1:0]      r_didx, w_didx_nxt;
  logic [DATA_W-1:0]     r_ddata, w_ddata_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;

  logic [IMEM_AW:0] w_len_clamp;
  logic             w_load_hs, w_load_last, w_run_last, w_dump_hs, w_dump_last;

  assign w_len_clamp = (load_len_i > MAX_LEN) ? MAX_LEN : load_len_i;
  assign w_load_hs   = instr_valid_i && (r_state == S_LOAD);
  assign w_load_last = (r_ptr == r_len - LEN_ONE);
  // r_cnt counts enabled cycles already elapsed; r_run is never 0 inside RUN.
  assign w_run_last  = (r_cnt == r_run - RUN_ONE);
  assign w_dump_hs   = (r_state == S_DUMP) && r_dvalid && dump_ready_i;
  assign w_dump_last = (r_idx == IDX_LAST);

  // State register (plus all registered outputs and counters)
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_run        <= '0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_cpu_en     <= 1'b0;
      r_dvalid     <= 1'b0;
      r_didx       <= '0;
      r_ddata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_run        <= w_run_nxt;
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_imem_we    <= w_imem_we_nxt;
      r_imem_addr  <= w_imem_addr_nxt;
      r_imem_wdata <= w_imem_wdata_nxt;
      r_cpu_rst_n  <= w_cpu_rst_n_nxt;
      r_cpu_en     <= w_cpu_en_nxt;
      r_dvalid     <= w_dvalid_nxt;
      r_didx       <= w_didx_nxt;
      r_ddata      <= w_ddata_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next-state logic; abort overrides everything else
  always_comb begin
    w_state_nxt = r_state;
    if (abort_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE:
          if (start_i) begin
            if (w_len_clamp != '0)       w_state_nxt = S_LOAD;
            else if (run_cycles_i != '0) w_state_nxt = S_RUN;
            else                         w_state_nxt = S_DUMP;
          end
        S_LOAD:
          if (w_load_hs && w_load_last)
            w_state_nxt = (r_run != '0) ? S_RUN : S_DUMP;
        S_RUN:
          if (w_run_last) w_state_nxt = S_DUMP;
        S_DUMP:
          if (w_dump_hs && w_dump_last) w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values (registered in the state register process)
  always_comb begin
    w_len_nxt        = r_len;
    w_run_nxt        = r_run;
    w_ptr_nxt        = r_ptr;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_imem_we_nxt    = 1'b0;
    w_imem_addr_nxt  = r_imem_addr;
    w_imem_wdata_nxt = r_imem_wdata;
    w_dvalid_nxt     = r_dvalid;
    w_didx_nxt       = r_didx;
    w_ddata_nxt      = r_ddata;
    if (abort_i) begin
      w_len_nxt        = '0;
      w_run_nxt        = '0;
      w_ptr_nxt        = '0;
      w_cnt_nxt        = '0;
      w_idx_nxt        = '0;
      w_imem_addr_nxt  = '0;
      w_imem_wdata_nxt = '0;
      w_dvalid_nxt     = 1'b0;
      w_didx_nxt       = '0;
      w_ddata_nxt      = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE:
          if (start_i) begin
            w_len_nxt    = w_len_clamp;
            w_run_nxt    = run_cycles_i;
            w_ptr_nxt    = '0;
            w_cnt_nxt    = '0;
            w_idx_nxt    = '0;
            w_dvalid_nxt = 1'b0;
          end
        S_LOAD:
          if (w_load_hs) begin
            w_imem_we_nxt    = 1'b1;
            w_imem_addr_nxt  = r_ptr[IMEM_AW-1:0];
            w_imem_wdata_nxt = instr_data_i;
            w_ptr_nxt        = r_ptr + LEN_ONE;
          end
        S_RUN:
          if (!w_run_last) w_cnt_nxt = r_cnt + RUN_ONE;
        S_DUMP:
          // rf_raddr_o has been stable for one cycle whenever valid is low.
          if (!r_dvalid) begin
            w_dvalid_nxt = 1'b1;
            w_ddata_nxt  = rf_rdata_i;
            w_didx_nxt   = r_idx;
          end else if (dump_ready_i) begin
            w_dvalid_nxt = 1'b0;
            if (!w_dump_last) w_idx_nxt = r_idx + IDX_ONE;
          end
        default: ;
      endcase
    end

    // CPU reset is released on entering RUN and then held through DUMP/DONE.
    case (w_state_nxt)
      S_RUN:          w_cpu_rst_n_nxt = 1'b1;
      S_IDLE, S_LOAD: w_cpu_rst_n_nxt = 1'b0;
      default:        w_cpu_rst_n_nxt = r_cpu_rst_n;
    endcase
    w_cpu_en_nxt = (w_state_nxt == S_RUN);
    w_busy_nxt   = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN) ||
                   (w_state_nxt == S_DUMP);
    w_done_nxt   = (w_state_nxt == S_DONE);
  end

  assign instr_ready_o = (r_state == S_LOAD);
  assign imem_we_o     = r_imem_we;
  assign imem_addr_o   = r_imem_addr;
  assign imem_wdata_o  = r_imem_wdata;
  assign cpu_rst_n_o   = r_cpu_rst_n;
  assign cpu_en_o      = r_cpu_en;
  assign rf_raddr_o    = r_idx;
  assign dump_valid_o  = r_dvalid;
  assign dump_idx_o    = r_didx;
  assign dump_data_o   = r_ddata;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign state_o       = r_state;
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run sequencer for Simple_Single_CPU. It loads a program into the instruction memory through a streaming handshake, then releases the CPU for a programmed number of cycles and freezes it. It then reads all 32 register-file entries out as a stream and signals completion. Together these give silicon-facing bring-up and regression control, and replace ad-hoc preload and dump in simulation.

Parameters:
IMEM_AW, 8, instruction-memory word-address width (depth = 2**IMEM_AW words)
RUN_CNT_W, 16, width of run-cycle counter
DATA_W, 32, instruction and register data width
NUM_REGS, 32, register-file entries dumped (index width 5)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  start request; sampled in IDLE/DONE only
abort_i  in  1  synchronous abort; any state -> IDLE
load_len_i  in  IMEM_AW+1  words to load; latched on start
run_cycles_i  in  RUN_CNT_W  CPU cycles to run; latched on start
instr_valid_i  in  1  instruction word valid
instr_ready_o  out  1  controller accepts word
instr_data_i  in  DATA_W  instruction word
imem_we_o  out  1  IMEM write enable
imem_addr_o  out  IMEM_AW  IMEM word address
imem_wdata_o  out  DATA_W  IMEM write data
cpu_rst_n_o  out  1  CPU reset, active-low
cpu_en_o  out  1  CPU clock enable (state update gate)
rf_raddr_o  out  5  register-file read address (combinational-read RF)
rf_rdata_i  in  DATA_W  register-file read data
dump_valid_o  out  1  dump beat valid
dump_ready_i  in  1  dump sink ready
dump_idx_o  out  5  register index of beat
dump_data_o  out  DATA_W  register value of beat
busy_o  out  1  high in LOAD/RUN/DUMP
done_o  out  1  high in DONE
state_o  out  3  IDLE=0 LOAD=1 RUN=2 DUMP=3 DONE=4

Behaviour:
- One clock domain clk_i. rst_i is asynchronous, active-low.
- Reset (rst_i=0) forces all of the following, regardless of state:
  - state IDLE
  - every output 0
  - counters 0
- All outputs are registered except instr_ready_o, which is 1 exactly when state==LOAD.
- IDLE:
  - cpu_rst_n_o=0, cpu_en_o=0.
  - On start_i=1: latch len = min(load_len_i, 2**IMEM_AW) and run_cycles_i.
  - len!=0 -> LOAD. len==0 and run!=0 -> RUN. Both 0 -> DUMP.
- LOAD:
  - cpu_rst_n_o=0.
  - Each edge with instr_valid_i&instr_ready_o: next cycle imem_we_o=1, imem_addr_o=ptr, imem_wdata_o=instr_data_i; ptr++.
  - imem_we_o is 0 in cycles following no handshake.
  - On the handshake of word len-1: run!=0 -> RUN, else -> DUMP.
- RUN:
  - cpu_rst_n_o=1 and cpu_en_o=1 for exactly run_cycles consecutive cycles, starting the cycle state_o==2 is first visible.
  - Then cpu_en_o=0 and -> DUMP.
- CPU hold rules:
  - cpu_rst_n_o stays 1 in DUMP and DONE so CPU state is preserved.
  - cpu_en_o is 0 in every state other than RUN.
- DUMP:
  - idx starts at 0; rf_raddr_o=idx.
  - One cycle after rf_raddr_o settles: dump_valid_o=1, dump_data_o=rf_rdata_i captured, dump_idx_o=idx.
  - While dump_valid_o&!dump_ready_i: valid, idx and data held stable.
  - On handshake: idx==NUM_REGS-1 -> DONE with valid=0; else idx++, valid=0 for one cycle, then the next beat.
  - Maximum throughput is one beat per 2 cycles.
- DONE:
  - done_o=1, busy_o=0.
  - start_i restarts exactly as from IDLE; LOAD forces cpu_rst_n_o back to 0.
- Ignored inputs: start_i outside IDLE/DONE is ignored. instr_valid_i outside LOAD is ignored.
- Abort: abort_i=1 at an edge in any state -> IDLE next cycle with all outputs 0. abort_i takes priority over start_i and over handshakes in the same cycle; no IMEM write or dump beat is issued for that cycle.
- Reset mid-operation: same end result as abort, applied immediately (asynchronously).
- Counter rules: ptr, run counter and idx never wrap. len clamps at 2**IMEM_AW, and the last address written is 2**IMEM_AW-1.

Test Plan:
1. Reset: hold rst_i=0 with random inputs -> all outputs 0, state_o=0. Release rst_i, no start -> remains IDLE, cpu_rst_n_o=0.
2. Load: start with load_len=4, run=10; send words 0x20080005, 0x20090003, 0x01095020, 0x00000000 with one idle cycle between words -> imem writes at addresses 0..3 with those data, one cycle after each handshake. Then state_o=2.
3. Run length: run_cycles=100 -> cpu_en_o high exactly 100 consecutive cycles; cpu_rst_n_o stays 1 into DUMP; against the full CPU, $10 reads 0x00000008 after program 2.
4. Dump backpressure: drive rf_rdata_i=0xA5000000|addr, hold dump_ready_i low 3 cycles at idx 5 -> beat 5 stable with data 0xA5000005. All 32 beats arrive with idx 0..31 in order, then done_o=1.
5. Zero cases: load_len=0, run=0 -> IDLE->DUMP directly, cpu_en_o never high. load_len=300 with IMEM_AW=8 -> 256 writes, last address 255.
6. Interruption: abort_i during RUN cycle 50 -> cpu_en_o=0 and cpu_rst_n_o=0 next cycle, state IDLE. rst_i low mid-DUMP -> dump_valid_o=0 immediately. A subsequent start runs cleanly.
